// File: rtl/pixel_streamer_if.sv
// Host/core signal bundle of the pixel streamer. The streamer uses the slave modport;
// the host pixel source, the accelerator core and the result consumer use master.
interface pixel_streamer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  s_valid;
    logic                  s_ready;
    logic [7:0]            s_pixel;
    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  core_valid;
    logic [3:0]            core_digit;
    logic                  r_valid;
    logic                  r_ready;
    logic [3:0]            r_digit;
    logic                  r_err;
    logic                  busy;

    modport master (
        output s_valid, s_pixel, core_valid, core_digit, r_ready,
        input  s_ready, pix_valid, pix_data, r_valid, r_digit, r_err, busy
    );

    modport slave (
        input  s_valid, s_pixel, core_valid, core_digit, r_ready,
        output s_ready, pix_valid, pix_data, r_valid, r_digit, r_err, busy
    );
endinterface

// File: rtl/pixel_streamer.sv
// Buffers one image of 8-bit host pixels, streams it as fixed point into the MNIST core and
// returns the core's digit on a valid/ready channel. PIXEL_STREAMER_TIMEOUT_EN adds a result timeout.
module pixel_streamer #(
    parameter int DATA_WIDTH     = 24,
    parameter int IMG_PIXELS     = 784,
    parameter int FRAC_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic            clk,
    input logic            rst,
    pixel_streamer_if.slave bus
);

    localparam int CNT_W  = $clog2(IMG_PIXELS + 1);
    localparam int ADDR_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam int SHIFT  = FRAC_BITS - 8;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMG_PIXELS - 1);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(IMG_PIXELS);

    if (FRAC_BITS < 8 || FRAC_BITS > DATA_WIDTH - 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("pixel_streamer: illegal FRAC_BITS / DATA_WIDTH / TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        WAIT,
        RESULT
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic                  pix_valid_q, pix_valid_d;
    logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;
    logic [3:0]            r_digit_q, r_digit_d;

    logic [7:0]            buffer [IMG_PIXELS];
    logic [7:0]            rd_pixel;
    logic                  accept;

`ifdef PIXEL_STREAMER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              r_err_q, r_err_d;
    logic              timeout;

    // Asserted in the TIMEOUT_CYCLES-th WAIT cycle; a core result in that same cycle still wins.
    assign timeout = (wait_cnt_q == WAIT_LAST);
`endif

    assign accept   = bus.s_valid && bus.s_ready;
    assign rd_pixel = buffer[rd_cnt_q[ADDR_W-1:0]];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        r_digit_d   = r_digit_q;
        pix_valid_d = 1'b0;
        pix_data_d  = '0;
`ifdef PIXEL_STREAMER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        r_err_d     = r_err_q;
`endif

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (wr_cnt_q == LAST_PIX) begin
                        state_d  = STREAM;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end

            STREAM: begin
                // rd_cnt runs one past the last address so the final beat leaves the output register.
                if (rd_cnt_q == END_CNT) begin
                    state_d  = WAIT;
                    rd_cnt_d = '0;
`ifdef PIXEL_STREAMER_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end else begin
                    rd_cnt_d    = rd_cnt_q + 1'b1;
                    pix_valid_d = 1'b1;
                    pix_data_d  = DATA_WIDTH'(rd_pixel) << SHIFT;
                end
            end

            WAIT: begin
                if (bus.core_valid) begin
                    state_d   = RESULT;
                    r_digit_d = bus.core_digit;
`ifdef PIXEL_STREAMER_TIMEOUT_EN
                    r_err_d   = 1'b0;
                end else if (timeout) begin
                    state_d   = RESULT;
                    r_digit_d = 4'hF;
                    r_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end

            RESULT: begin
                if (bus.r_ready) begin
                    state_d = FILL;
                end
            end

            default: state_d = FILL;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            r_digit_q   <= 4'h0;
`ifdef PIXEL_STREAMER_TIMEOUT_EN
            wait_cnt_q  <= '0;
            r_err_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            r_digit_q   <= r_digit_d;
`ifdef PIXEL_STREAMER_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            r_err_q     <= r_err_d;
`endif
        end
    end

    // NOTE: the image buffer is deliberately not reset; a reset abandons the image anyway.
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[wr_cnt_q[ADDR_W-1:0]] <= bus.s_pixel;
        end
    end

    // Outputs are forced low while rst is high, including the first cycle before the reset edge.
    assign bus.s_ready   = !rst && (state_q == FILL);
    assign bus.busy      = !rst && (state_q != FILL);
    assign bus.r_valid   = !rst && (state_q == RESULT);
    assign bus.pix_valid = !rst && pix_valid_q;
    assign bus.pix_data  = rst ? '0 : pix_data_q;
    assign bus.r_digit   = rst ? 4'h0 : r_digit_q;
`ifdef PIXEL_STREAMER_TIMEOUT_EN
    assign bus.r_err     = !rst && r_err_q;
`else
    assign bus.r_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer (4-pixel image, FRAC_BITS=16, TIMEOUT_CYCLES=16);
// streamed pixels are checked against a scoreboard queue filled as the host pixels are accepted.
module tb_pixel_streamer;

    localparam int DW  = 24;
    localparam int PIX = 4;
    localparam int FB  = 16;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_streamer_if #(.DATA_WIDTH(DW)) sb();

    pixel_streamer #(
        .DATA_WIDTH    (DW),
        .IMG_PIXELS    (PIX),
        .FRAC_BITS     (FB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sb.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];
    logic [7:0]    img[PIX];
    int            acc_cyc;
    int            first_cyc;
    logic          ready_after;
    logic          early_pv;

    function automatic logic [DW-1:0] pix_model(input logic [7:0] p);
        return DW'(p) * (DW'(1) << (FB - 8));
    endfunction

    // Sends img[] to the streamer, optionally idling s_valid every other cycle; records the last accept.
    task automatic fill(input bit throttle);
        int  sent  = 0;
        int  guard = 0;
        bit  idle  = 1'b0;
        while (sent < PIX && guard < 40) begin
            @(negedge clk);
            guard++;
            if (throttle && idle) begin
                sb.s_valid = 1'b0;
                sb.s_pixel = 8'hAA;
            end else begin
                sb.s_valid = 1'b1;
                sb.s_pixel = img[sent];
            end
            idle = !idle;
            #1;
            if (sb.s_valid && sb.s_ready) begin
                exp_q.push_back(pix_model(img[sent]));
                acc_cyc = cyc;
                sent++;
            end
        end
        if (sent < PIX) begin
            n_checks++; n_fail++;
            $display("FAIL fill_bound: accepted %0d pixels, required %0d", sent, PIX);
        end
        @(negedge clk);
        sb.s_valid = 1'b0;
        sb.s_pixel = 8'h00;
        #1;
        ready_after = sb.s_ready;
        early_pv    = sb.pix_valid;
    endtask

    // Records one contiguous burst; returns at the first idle cycle after it (the first WAIT cycle).
    task automatic collect();
        obs_q.delete();
        first_cyc = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (sb.pix_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                obs_q.push_back(sb.pix_data);
            end else if (first_cyc >= 0) begin
                break;
            end
        end
    endtask

    task automatic finish_image(input logic [3:0] d, output logic got_v, output logic [3:0] got_d,
                                output logic got_rdy);
        sb.core_valid = 1'b1;
        sb.core_digit = d;
        @(negedge clk);
        sb.core_valid = 1'b0;
        got_v = sb.r_valid;
        got_d = sb.r_digit;
        sb.r_ready = 1'b1;
        @(negedge clk);
        sb.r_ready = 1'b0;
        #1;
        got_rdy = sb.s_ready;
    endtask

    task automatic test_reset();
        int stray = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (sb.s_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_s_ready: got %b want 0", sb.s_ready); end
        n_checks++; if (sb.busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", sb.busy); end
        n_checks++; if (sb.pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pix_valid: got %b want 0", sb.pix_valid); end
        n_checks++; if (sb.pix_data !== '0)    begin n_fail++; $display("FAIL rst_pix_data: got %h want 0", sb.pix_data); end
        n_checks++; if (sb.r_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_r_valid: got %b want 0", sb.r_valid); end
        n_checks++; if (sb.r_digit !== 4'h0)   begin n_fail++; $display("FAIL rst_r_digit: got %h want 0", sb.r_digit); end
        n_checks++; if (sb.r_err !== 1'b0)     begin n_fail++; $display("FAIL rst_r_err: got %b want 0", sb.r_err); end
        rst = 1'b0;
        #1;
        n_checks++; if (sb.s_ready !== 1'b1)   begin n_fail++; $display("FAIL rel_s_ready: got %b want 1", sb.s_ready); end

        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        fill(1'b0);
        @(negedge clk);
        n_checks++; if (sb.pix_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_streaming: got %b want 1", sb.pix_valid); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (sb.pix_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_pix_valid: got %b want 0", sb.pix_valid); end
        n_checks++; if (sb.pix_data !== '0)    begin n_fail++; $display("FAIL midrst_pix_data: got %h want 0", sb.pix_data); end
        rst = 1'b0;
        #1;
        n_checks++; if (sb.pix_valid !== 1'b0) begin n_fail++; $display("FAIL post_pix_valid: got %b want 0", sb.pix_valid); end
        n_checks++; if (sb.r_valid !== 1'b0)   begin n_fail++; $display("FAIL post_r_valid: got %b want 0", sb.r_valid); end
        n_checks++; if (sb.busy !== 1'b0)      begin n_fail++; $display("FAIL post_busy: got %b want 0", sb.busy); end
        n_checks++; if (sb.s_ready !== 1'b1)   begin n_fail++; $display("FAIL post_s_ready: got %b want 1", sb.s_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sb.pix_valid) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL post_stray_beats: got %0d want 0", stray); end
        exp_q.delete();
    endtask

    task automatic test_basic();
        logic [DW-1:0] e, g;
        logic v, rdy;
        logic [3:0] d;
        img = '{8'h00, 8'h01, 8'h80, 8'hFF};
        fill(1'b0);
        n_checks++; if (ready_after !== 1'b0) begin n_fail++; $display("FAIL basic_s_ready_drop: got %b want 0", ready_after); end
        n_checks++; if (early_pv !== 1'b0)    begin n_fail++; $display("FAIL basic_early_beat: got %b want 0", early_pv); end
        collect();
        n_checks++; if (first_cyc != acc_cyc + 2) begin n_fail++; $display("FAIL basic_latency: first beat cycle %0d want %0d", first_cyc, acc_cyc + 2); end
        n_checks++; if (obs_q.size() != PIX) begin n_fail++; $display("FAIL basic_beats: got %0d want %0d", obs_q.size(), PIX); end
        for (int i = 0; i < PIX; i++) begin
            e = exp_q.pop_front();
            g = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, g, e); end
        end
        n_checks++; if (sb.busy !== 1'b1)    begin n_fail++; $display("FAIL basic_wait_busy: got %b want 1", sb.busy); end
        n_checks++; if (sb.r_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_r_valid: got %b want 0", sb.r_valid); end
        finish_image(4'd1, v, d, rdy);
        n_checks++; if (d !== 4'd1) begin n_fail++; $display("FAIL basic_digit: got %h want 1", d); end
    endtask

    task automatic test_throttle();
        logic [DW-1:0] e, g;
        logic v, rdy;
        logic [3:0] d;
        img = '{8'h12, 8'h34, 8'h56, 8'h78};
        fill(1'b1);
        n_checks++; if (ready_after !== 1'b0) begin n_fail++; $display("FAIL thr_s_ready_drop: got %b want 0", ready_after); end
        collect();
        n_checks++; if (first_cyc != acc_cyc + 2) begin n_fail++; $display("FAIL thr_latency: first beat cycle %0d want %0d", first_cyc, acc_cyc + 2); end
        n_checks++; if (obs_q.size() != PIX) begin n_fail++; $display("FAIL thr_beats: got %0d want %0d", obs_q.size(), PIX); end
        for (int i = 0; i < PIX; i++) begin
            e = exp_q.pop_front();
            g = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL thr_data[%0d]: got %h want %h", i, g, e); end
        end
        finish_image(4'd2, v, d, rdy);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL thr_r_valid: got %b want 1", v); end
    endtask

    task automatic test_result_handshake();
        for (int i = 0; i < PIX; i++) img[i] = 8'($urandom_range(0, 255));
        fill(1'b0);
        collect();
        exp_q.delete();
        sb.core_valid = 1'b1;
        sb.core_digit = 4'd7;
        sb.r_ready    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sb.core_valid = (i == 2);
            sb.core_digit = (i == 2) ? 4'd2 : 4'hC;
            n_checks++; if (sb.r_valid !== 1'b1) begin n_fail++; $display("FAIL hs_r_valid[%0d]: got %b want 1", i, sb.r_valid); end
            n_checks++; if (sb.r_digit !== 4'd7) begin n_fail++; $display("FAIL hs_r_digit[%0d]: got %h want 7", i, sb.r_digit); end
        end
        n_checks++; if (sb.r_err !== 1'b0) begin n_fail++; $display("FAIL hs_r_err: got %b want 0", sb.r_err); end
        @(negedge clk);
        sb.core_valid = 1'b0;
        sb.r_ready = 1'b1;
        n_checks++; if (sb.r_digit !== 4'd7) begin n_fail++; $display("FAIL hs_ignored_core: got %h want 7", sb.r_digit); end
        @(negedge clk);
        sb.r_ready = 1'b0;
        #1;
        n_checks++; if (sb.r_valid !== 1'b0) begin n_fail++; $display("FAIL hs_drop_r_valid: got %b want 0", sb.r_valid); end
        n_checks++; if (sb.s_ready !== 1'b1) begin n_fail++; $display("FAIL hs_s_ready: got %b want 1", sb.s_ready); end
        n_checks++; if (sb.busy !== 1'b0)    begin n_fail++; $display("FAIL hs_busy: got %b want 0", sb.busy); end
    endtask

    task automatic test_spurious();
        img = '{8'h05, 8'h50, 8'hA5, 8'h5A};
        sb.core_valid = 1'b1;
        sb.core_digit = 4'd3;
        fill(1'b0);
        collect();
        exp_q.delete();
        sb.core_valid = 1'b0;
        n_checks++; if (sb.r_valid !== 1'b0) begin n_fail++; $display("FAIL spur_r_valid_early: got %b want 0", sb.r_valid); end
        repeat (2) @(negedge clk);
        n_checks++; if (sb.r_valid !== 1'b0) begin n_fail++; $display("FAIL spur_r_valid_wait: got %b want 0", sb.r_valid); end
        sb.core_valid = 1'b1;
        sb.core_digit = 4'd5;
        @(negedge clk);
        sb.core_valid = 1'b0;
        n_checks++; if (sb.r_valid !== 1'b1) begin n_fail++; $display("FAIL spur_r_valid: got %b want 1", sb.r_valid); end
        n_checks++; if (sb.r_digit !== 4'd5) begin n_fail++; $display("FAIL spur_r_digit: got %h want 5", sb.r_digit); end
        sb.r_ready = 1'b1;
        @(negedge clk);
        sb.r_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e, g;
        logic v, rdy;
        logic [3:0] d, want;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < PIX; i++) img[i] = 8'($urandom_range(0, 255));
            want = 4'($urandom_range(0, 9));
            fill(1'b0);
            collect();
            n_checks++; if (obs_q.size() != PIX) begin n_fail++; $display("FAIL b2b_beats[%0d]: got %0d want %0d", n, obs_q.size(), PIX); end
            for (int i = 0; i < PIX; i++) begin
                e = exp_q.pop_front();
                g = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
                n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_data[%0d][%0d]: got %h want %h", n, i, g, e); end
            end
            finish_image(want, v, d, rdy);
            n_checks++; if (d !== want)  begin n_fail++; $display("FAIL b2b_digit[%0d]: got %h want %h", n, d, want); end
            n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_s_ready[%0d]: got %b want 1", n, rdy); end
        end
    endtask

`ifdef PIXEL_STREAMER_TIMEOUT_EN
    task automatic test_timeout();
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        fill(1'b0);
        collect();
        exp_q.delete();
        repeat (TO - 1) @(negedge clk);
        n_checks++; if (sb.r_valid !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", sb.r_valid); end
        @(negedge clk);
        n_checks++; if (sb.r_valid !== 1'b1) begin n_fail++; $display("FAIL to_r_valid: got %b want 1", sb.r_valid); end
        n_checks++; if (sb.r_digit !== 4'hF) begin n_fail++; $display("FAIL to_r_digit: got %h want F", sb.r_digit); end
        n_checks++; if (sb.r_err !== 1'b1)   begin n_fail++; $display("FAIL to_r_err: got %b want 1", sb.r_err); end
        sb.r_ready = 1'b1;
        @(negedge clk);
        sb.r_ready = 1'b0;

        fill(1'b0);
        collect();
        exp_q.delete();
        repeat (TO - 1) @(negedge clk);
        sb.core_valid = 1'b1;
        sb.core_digit = 4'd9;
        @(negedge clk);
        sb.core_valid = 1'b0;
        n_checks++; if (sb.r_valid !== 1'b1) begin n_fail++; $display("FAIL tie_r_valid: got %b want 1", sb.r_valid); end
        n_checks++; if (sb.r_digit !== 4'd9) begin n_fail++; $display("FAIL tie_r_digit: got %h want 9", sb.r_digit); end
        n_checks++; if (sb.r_err !== 1'b0)   begin n_fail++; $display("FAIL tie_r_err: got %b want 0", sb.r_err); end
        sb.r_ready = 1'b1;
        @(negedge clk);
        sb.r_ready = 1'b0;
    endtask
`endif

    initial begin
        sb.s_valid    = 1'b0;
        sb.s_pixel    = 8'h00;
        sb.core_valid = 1'b0;
        sb.core_digit = 4'h0;
        sb.r_ready    = 1'b0;
        test_reset();
        test_basic();
        test_throttle();
        test_result_handshake();
        test_spurious();
        test_back_to_back();
`ifdef PIXEL_STREAMER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
